// File: rtl/key_debounce_pulse_pkg.sv
// key_debounce_pulse_pkg: shared repeat-FSM states, default timing and counter sizing helper.
package key_debounce_pulse_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_e;

    localparam int DEF_NUM_KEYS     = 4;
    localparam int DEF_DB_DEPTH     = 4;
    localparam int DEF_REPEAT_DELAY = 75;
    localparam int DEF_REPEAT_RATE  = 15;

    function automatic int cnt_width(input int a, input int b);
        return $clog2((a > b ? a : b) + 1);
    endfunction

endpackage

// File: rtl/key_debounce_pulse_channel.sv
// key_debounce_pulse_channel: one key's synchronizer, tick-sampled debounce history, press pulse and auto-repeat FSM.
module key_debounce_pulse_channel
    import key_debounce_pulse_pkg::*;
#(
    parameter int DB_DEPTH     = DEF_DB_DEPTH,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_i,
    input  logic key_i,
    output logic level_o,
    output logic pulse_o,
    output logic repeat_o
);

    localparam int              CW         = cnt_width(REPEAT_DELAY, REPEAT_RATE);
    localparam logic [CW-1:0]   DELAY_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0]   RATE_LAST  = CW'(REPEAT_RATE - 1);

    logic [1:0]          sync_q;
    logic [DB_DEPTH-1:0] hist_q, hist_d;
    logic                level_q, pulse_q, repeat_q;
    logic                rise, fall;
    rep_state_e          state_q;
    logic [CW-1:0]       cnt_q;

    always_comb begin
        hist_d = tick_i ? {hist_q[DB_DEPTH-2:0], sync_q[1]} : hist_q;
        rise   = tick_i & (&hist_d) & ~level_q;
        fall   = tick_i & ~(|hist_d) & level_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            hist_q  <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], key_i};
            hist_q  <= hist_d;
            level_q <= rise | (level_q & ~fall);
            pulse_q <= rise;
        end
    end

    // A falling level takes priority, so a repeat due on the same tick is dropped.
    always_ff @(posedge clk) begin
        if (rst || fall) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            repeat_q <= 1'b0;
        end else begin
            repeat_q <= 1'b0;
            case (state_q)
                IDLE: if (rise) begin
                    state_q <= DELAY;
                    cnt_q   <= '0;
                end
                DELAY: if (tick_i) begin
                    if (cnt_q == DELAY_LAST) begin
                        state_q  <= REPEAT;
                        cnt_q    <= '0;
                        repeat_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                REPEAT: if (tick_i) begin
                    repeat_q <= (cnt_q == RATE_LAST);
                    cnt_q    <= (cnt_q == RATE_LAST) ? '0 : cnt_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign level_o  = level_q;
    assign pulse_o  = pulse_q;
    assign repeat_o = repeat_q;

endmodule

// File: rtl/key_debounce_pulse.sv
// key_debounce_pulse: detects clk_150 rising edges as a shared scan tick and debounces NUM_KEYS buttons.
module key_debounce_pulse
    import key_debounce_pulse_pkg::*;
#(
    parameter int NUM_KEYS     = DEF_NUM_KEYS,
    parameter int DB_DEPTH     = DEF_DB_DEPTH,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clk_150,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_pulse,
    output logic [NUM_KEYS-1:0] key_repeat
);

    logic clk_150_q;
    logic tick;

    // Resetting to 1 keeps a high clk_150 from looking like a fresh edge right after reset.
    always_ff @(posedge clk) begin
        if (rst) clk_150_q <= 1'b1;
        else     clk_150_q <= clk_150;
    end

    assign tick = clk_150 & ~clk_150_q;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_ch
        key_debounce_pulse_channel #(
            .DB_DEPTH    (DB_DEPTH),
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_RATE (REPEAT_RATE)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .tick_i  (tick),
            .key_i   (key_in[k]),
            .level_o (key_level[k]),
            .pulse_o (key_pulse[k]),
            .repeat_o(key_repeat[k])
        );
    end

endmodule

// File: tb/tb_key_debounce_pulse.sv
// tb_key_debounce_pulse: directed checks of reset, debounce, press pulse, auto-repeat and reset-while-held.
module tb_key_debounce_pulse;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_150 = 1'b1;
    logic [3:0] key_in = 4'b0000;
    logic [3:0] key_level, key_pulse, key_repeat;

    int total = 0, bad = 0, ovl = 0, wide = 0;
    int pcnt[4], rcnt[4];
    logic [3:0] prev_rep = 4'b0000;
    logic [3:0] lvl_t, pul_t, rep_t;

    always #5 clk = ~clk;

    key_debounce_pulse #(
        .NUM_KEYS    (4),
        .DB_DEPTH    (4),
        .REPEAT_DELAY(6),
        .REPEAT_RATE (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_150   (clk_150),
        .key_in    (key_in),
        .key_level (key_level),
        .key_pulse (key_pulse),
        .key_repeat(key_repeat)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            pcnt[k] += int'(key_pulse[k]);
            rcnt[k] += int'(key_repeat[k]);
        end
        if (|(key_pulse & key_repeat)) ovl++;
        if (|(key_repeat & prev_rep)) wide++;
        prev_rep = key_repeat;
    endtask

    // One clk_150 period: 4 low cycles, then the rising edge is consumed by the next clk edge.
    task automatic tick();
        clk_150 = 1'b0;
        repeat (4) cycle();
        clk_150 = 1'b1;
        cycle();
        lvl_t = key_level;
        pul_t = key_pulse;
        rep_t = key_repeat;
        repeat (3) cycle();
    endtask

    task automatic clr();
        for (int k = 0; k < 4; k++) begin
            pcnt[k] = 0;
            rcnt[k] = 0;
        end
    endtask

    initial begin
        clr();
        repeat (3) cycle();
        chk("rst_level", key_level, 4'h0);
        chk("rst_pulse", key_pulse, 4'h0);
        chk("rst_repeat", key_repeat, 4'h0);
        rst = 1'b0;
        cycle();
        chk("post_rst_level", key_level, 4'h0);
        chk("post_rst_pulse", key_pulse, 4'h0);

        clr();
        key_in = 4'b0001;
        repeat (3) tick();
        chk("press_lvl_pre", key_level[0], 1'b0);
        tick();
        chk("press_lvl", lvl_t[0], 1'b1);
        chk("press_pulse", pul_t[0], 1'b1);
        chk("press_pulse_cnt", pcnt[0], 1);
        chk("press_pulse_off", key_pulse[0], 1'b0);
        chk("press_no_rep", rcnt[0], 0);

        key_in[1] = 1'b1; tick();
        key_in[1] = 1'b0; tick();
        key_in[1] = 1'b1; tick();
        key_in[1] = 1'b0;
        repeat (3) tick();
        chk("bounce_lvl", key_level[1], 1'b0);
        chk("bounce_pulse", pcnt[1], 0);
        chk("bounce_rep", rcnt[1], 0);
        chk("k0_first_rep", rcnt[0], 1);

        clr();
        key_in[2] = 1'b1;
        repeat (4) tick();
        chk("rep_rise", lvl_t[2], 1'b1);
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk($sformatf("rep_tick%0d", i), rep_t[2], (i >= 6 && (i - 6) % 3 == 0));
        end
        chk("rep_count", rcnt[2], 5);
        chk("rep_pulse_cnt", pcnt[2], 1);

        clr();
        key_in[3] = 1'b1;
        repeat (4) tick();
        chk("rel_rise", lvl_t[3], 1'b1);
        repeat (2) tick();
        key_in[3] = 1'b0;
        repeat (3) tick();
        chk("rel_lvl_hold", key_level[3], 1'b1);
        tick();
        chk("rel_fall", lvl_t[3], 1'b0);
        chk("rel_no_rep_at_fall", rep_t[3], 1'b0);
        repeat (6) tick();
        chk("rel_idle_no_rep", rcnt[3], 0);
        key_in[3] = 1'b1;
        repeat (4) tick();
        chk("repress_pulse", pul_t[3], 1'b1);
        chk("repress_pulse_cnt", pcnt[3], 2);

        chk("pre_rst_k0", key_level[0], 1'b1);
        key_in = 4'b1111;
        rst = 1'b1;
        repeat (2) cycle();
        chk("midrst_level", key_level, 4'h0);
        chk("midrst_pulse", key_pulse, 4'h0);
        chk("midrst_repeat", key_repeat, 4'h0);
        rst = 1'b0;
        clr();
        repeat (3) tick();
        chk("rerise_pre", key_level, 4'h0);
        tick();
        chk("rerise_lvl", lvl_t, 4'hf);
        chk("rerise_pulse", pul_t, 4'hf);
        chk("rerise_pulse_k0", pcnt[0], 1);

        chk("no_overlap", ovl, 0);
        chk("rep_width", wide, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
